// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 datapath: LOAD, ARK, 9x(SB,SR,MC,ARK), SB,SR,ARK, FINISH.
// Define AES_CTRL_TIMEOUT_EN to add the stage watchdog and the err output.
module aes_round_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned RND_W      = 4
`ifdef AES_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT    = 64
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             load,
    output logic             ark_en,
    output logic             sb_en,
    output logic             sr_en,
    output logic             mc_en,
    input  logic             ark_done,
    input  logic             sb_done,
    input  logic             sr_done,
    input  logic             mc_done,
    output logic [RND_W-1:0] round,
    output logic [1:0]       state_sel,
    output logic             busy,
    output logic             done
`ifdef AES_CTRL_TIMEOUT_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARK,
        S_SB,
        S_SR,
        S_MC,
        S_FINISH
    } state_t;

    localparam logic [RND_W-1:0] LP_LAST_RND = RND_W'(NUM_ROUNDS);

    state_t           r_state;
    state_t           w_next;
    logic             r_first;
    logic             w_stage;
    logic             w_stage_done;
    logic             w_accept;
    logic             w_timeout;

    logic             r_load;
    logic             r_ark_en;
    logic             r_sb_en;
    logic             r_sr_en;
    logic             r_mc_en;
    logic [RND_W-1:0] r_round;
    logic [1:0]       r_sel;
    logic             r_busy;
    logic             r_done;

`ifdef AES_CTRL_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] LP_WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_err;
`endif

    // r_first masks a done that is still high from the previous stage visit
    always_comb begin
        w_stage      = 1'b0;
        w_stage_done = 1'b0;
        case (r_state)
            S_ARK:   begin w_stage = 1'b1; w_stage_done = ark_done; end
            S_SB:    begin w_stage = 1'b1; w_stage_done = sb_done;  end
            S_SR:    begin w_stage = 1'b1; w_stage_done = sr_done;  end
            S_MC:    begin w_stage = 1'b1; w_stage_done = mc_done;  end
            default: ;
        endcase
        w_accept = w_stage && !r_first && w_stage_done;
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD;
            S_LOAD:   w_next = S_ARK;
            S_ARK:    if (w_accept) w_next = (r_round == LP_LAST_RND) ? S_FINISH : S_SB;
            S_SB:     if (w_accept) w_next = S_SR;
            S_SR:     if (w_accept) w_next = (r_round < LP_LAST_RND) ? S_MC : S_ARK;
            S_MC:     if (w_accept) w_next = S_ARK;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
`ifdef AES_CTRL_TIMEOUT_EN
        // Watchdog wins over a done arriving in the same cycle
        if (w_stage && r_wdog == LP_WD_LAST) begin
            w_next    = S_IDLE;
            w_timeout = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next;
            r_first <= (w_next != r_state);
        end
    end

    // Outputs are registered from the next state so they line up with r_state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load   <= 1'b0;
            r_ark_en <= 1'b0;
            r_sb_en  <= 1'b0;
            r_sr_en  <= 1'b0;
            r_mc_en  <= 1'b0;
            r_round  <= '0;
            r_sel    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_load   <= (w_next == S_LOAD);
            r_ark_en <= (w_next == S_ARK);
            r_sb_en  <= (w_next == S_SB);
            r_sr_en  <= (w_next == S_SR);
            r_mc_en  <= (w_next == S_MC);
            r_busy   <= (w_next != S_IDLE);
            r_done   <= (w_next == S_FINISH);
            case (w_next)
                S_SB:    r_sel <= 2'd1;
                S_SR:    r_sel <= 2'd2;
                S_MC:    r_sel <= 2'd3;
                default: r_sel <= 2'd0;
            endcase
            if (w_next == S_LOAD) begin
                r_round <= '0;
            end else if (r_state == S_ARK && w_next == S_SB) begin
                r_round <= r_round + 1'b1;
            end
        end
    end

`ifdef AES_CTRL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_next != r_state || !w_stage) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + 1'b1;
            end
        end
    end

    assign err = r_err;
`endif

    assign load      = r_load;
    assign ark_en    = r_ark_en;
    assign sb_en     = r_sb_en;
    assign sr_en     = r_sr_en;
    assign mc_en     = r_mc_en;
    assign round     = r_round;
    assign state_sel = r_sel;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: stage done models, timing, sequence, stall, stale done, reset, watchdog.
module tb_aes_round_ctrl;

    localparam int NUM_ROUNDS = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       load, ark_en, sb_en, sr_en, mc_en;
    logic       ark_done, sb_done, sr_done, mc_done;
    logic       ark_done_r;
    logic [3:0] round;
    logic [1:0] state_sel;
    logic       busy, done;
`ifdef AES_CTRL_TIMEOUT_EN
    logic       err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bit ark_stuck      = 1'b0;
    int sb_stall_round = -1;
    int mc_hang_round  = -1;
    int sb_cnt;

    aes_round_ctrl #(.NUM_ROUNDS(10), .RND_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .load(load),
        .ark_en(ark_en), .sb_en(sb_en), .sr_en(sr_en), .mc_en(mc_en),
        .ark_done(ark_done), .sb_done(sb_done), .sr_done(sr_done), .mc_done(mc_done),
        .round(round), .state_sel(state_sel), .busy(busy), .done(done)
`ifdef AES_CTRL_TIMEOUT_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    // Stage models: done one cycle after en is sampled; SB may stall, MC may hang
    always @(posedge clk) begin
        if (rst) begin
            ark_done_r <= 1'b0;
            sb_done    <= 1'b0;
            sr_done    <= 1'b0;
            mc_done    <= 1'b0;
            sb_cnt     <= 0;
        end else begin
            ark_done_r <= ark_en;
            sr_done    <= sr_en;
            mc_done    <= mc_en && (int'(round) != mc_hang_round);
            sb_cnt     <= sb_en ? sb_cnt + 1 : 0;
            sb_done    <= sb_en && (sb_cnt + 1 >= ((int'(round) == sb_stall_round) ? 5 : 1));
        end
    end
    assign ark_done = ark_stuck | ark_done_r;

    int load_cyc, load_cnt, done_cyc, done_cnt;
    int busy_first, busy_last, busy_cnt;
    int overlap, mc10, sel_bad, end_round;
    int ark_run, ark_min, sb_run, sb_max, mc_run, mc_max;
    int err_cyc, err_cnt, busy81;
    int seq[$];

    task automatic run_cipher(input int limit, input int s1, input int s2);
        int prev;
        int code;
        load_cyc = -1; load_cnt = 0; done_cyc = -1; done_cnt = 0;
        busy_first = -1; busy_last = -1; busy_cnt = 0;
        overlap = 0; mc10 = 0; sel_bad = 0; end_round = -1;
        ark_run = 0; ark_min = 1000; sb_run = 0; sb_max = 0; mc_run = 0; mc_max = 0;
        err_cyc = -1; err_cnt = 0; busy81 = -1;
        seq.delete();
        prev = -1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (load) begin load_cnt++; load_cyc = c; end
            if (done) begin done_cnt++; done_cyc = c; end
            if (busy) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
                busy_cnt++;
            end
            if (c == 81) busy81 = int'(busy);
`ifdef AES_CTRL_TIMEOUT_EN
            if (err) begin err_cnt++; err_cyc = c; end
`endif
            if (int'(ark_en) + int'(sb_en) + int'(sr_en) + int'(mc_en) > 1) overlap++;
            if (mc_en && round == 4'd10) mc10++;
            code = ark_en ? 0 : sb_en ? 1 : sr_en ? 2 : mc_en ? 3 : -1;
            if (code >= 0 && code != prev) seq.push_back(code);
            if (code >= 0 && int'(state_sel) != code) sel_bad++;
            prev = code;
            if (ark_en) ark_run++;
            else if (ark_run > 0) begin
                if (ark_run < ark_min) ark_min = ark_run;
                ark_run = 0;
            end
            if (sb_en) begin sb_run++; if (sb_run > sb_max) sb_max = sb_run; end
            else sb_run = 0;
            if (mc_en) begin mc_run++; if (mc_run > mc_max) mc_max = mc_run; end
            else mc_run = 0;
            end_round = int'(round);
            start = (c == s1 || c == s2);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({load, busy, done, ark_en, sb_en, sr_en, mc_en} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000", {load, busy, done, ark_en, sb_en, sr_en, mc_en});
        end
        n_checks++;
        if (round !== 4'd0) begin n_fail++; $display("FAIL reset_round: got %0d expected 0", round); end
        n_checks++;
        if (state_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d expected 0", state_sel); end
`ifdef AES_CTRL_TIMEOUT_EN
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        run_cipher(100, -1, -1);
        n_checks++;
        if (load_cyc != 1 || load_cnt != 1) begin n_fail++; $display("FAIL nom_load: got cyc %0d cnt %0d expected cyc 1 cnt 1", load_cyc, load_cnt); end
        n_checks++;
        if (done_cyc != 82 || done_cnt != 1) begin n_fail++; $display("FAIL nom_done: got cyc %0d cnt %0d expected cyc 82 cnt 1", done_cyc, done_cnt); end
        n_checks++;
        if (busy_first != 1 || busy_last != 82 || busy_cnt != 82) begin
            n_fail++; $display("FAIL nom_busy: got %0d..%0d (%0d) expected 1..82 (82)", busy_first, busy_last, busy_cnt);
        end
        n_checks++;
        if (end_round != NUM_ROUNDS) begin n_fail++; $display("FAIL nom_round: got %0d expected 10", end_round); end
    endtask

    task automatic test_sequence();
        int exp_q[$];
        int bad;
        exp_q.push_back(0);
        for (int r = 1; r < NUM_ROUNDS; r++) begin
            exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0);
        end
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
        run_cipher(100, -1, -1);
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < seq.size(); i++)
            if (seq[i] != exp_q[i]) bad++;
        n_checks++;
        if (seq.size() != 40) begin n_fail++; $display("FAIL seq_len: got %0d expected 40", seq.size()); end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL seq_order: got %0d wrong entries expected 0", bad); end
        n_checks++;
        if (overlap != 0) begin n_fail++; $display("FAIL seq_onehot: got %0d overlap cycles expected 0", overlap); end
        n_checks++;
        if (mc10 != 0) begin n_fail++; $display("FAIL seq_no_mc_final: got %0d cycles expected 0", mc10); end
        n_checks++;
        if (sel_bad != 0) begin n_fail++; $display("FAIL seq_state_sel: got %0d bad cycles expected 0", sel_bad); end
        n_checks++;
        if (ark_min != 2) begin n_fail++; $display("FAIL seq_ark_len: got %0d expected 2", ark_min); end
    endtask

    task automatic test_stall();
        sb_stall_round = 3;
        run_cipher(100, -1, -1);
        sb_stall_round = -1;
        n_checks++;
        if (sb_max != 6) begin n_fail++; $display("FAIL stall_sb_len: got %0d expected 6", sb_max); end
        n_checks++;
        if (done_cyc != 86 || done_cnt != 1) begin n_fail++; $display("FAIL stall_done: got cyc %0d cnt %0d expected cyc 86 cnt 1", done_cyc, done_cnt); end
        n_checks++;
        if (overlap != 0) begin n_fail++; $display("FAIL stall_onehot: got %0d expected 0", overlap); end
    endtask

    task automatic test_stale_start();
        ark_stuck = 1'b1;
        run_cipher(100, 20, 82);
        ark_stuck = 1'b0;
        n_checks++;
        if (ark_min != 2) begin n_fail++; $display("FAIL stale_ark_len: got %0d expected 2", ark_min); end
        n_checks++;
        if (done_cnt != 1 || done_cyc != 82) begin n_fail++; $display("FAIL stale_done: got cyc %0d cnt %0d expected cyc 82 cnt 1", done_cyc, done_cnt); end
        n_checks++;
        if (load_cnt != 1 || busy_cnt != 82) begin n_fail++; $display("FAIL stale_restart: got loads %0d busy %0d expected 1 82", load_cnt, busy_cnt); end
    endtask

    task automatic test_reset_mid();
        int dn;
        int bz;
        dn = 0;
        bz = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done) dn++;
            if (c == 41) begin
                n_checks++;
                if ({load, busy, done, ark_en, sb_en, sr_en, mc_en} !== 7'b0 || round !== 4'd0 || state_sel !== 2'd0) begin
                    n_fail++; $display("FAIL rstmid_outputs: got %b rnd %0d sel %0d expected all 0",
                        {load, busy, done, ark_en, sb_en, sr_en, mc_en}, round, state_sel);
                end
            end
            if (c > 41 && busy) bz++;
            rst = (c == 40);
        end
        rst = 1'b0;
        n_checks++;
        if (dn != 0 || bz != 0) begin n_fail++; $display("FAIL rstmid_idle: got done %0d busy %0d expected 0 0", dn, bz); end
        run_cipher(100, -1, -1);
        n_checks++;
        if (done_cyc != 82 || done_cnt != 1 || end_round != NUM_ROUNDS) begin
            n_fail++; $display("FAIL rstmid_rerun: got cyc %0d cnt %0d rnd %0d expected 82 1 10", done_cyc, done_cnt, end_round);
        end
    endtask

`ifdef AES_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        mc_hang_round = 2;
        run_cipher(100, -1, -1);
        mc_hang_round = -1;
        n_checks++;
        if (err_cyc != 80 || err_cnt != 1) begin n_fail++; $display("FAIL to_err: got cyc %0d cnt %0d expected cyc 80 cnt 1", err_cyc, err_cnt); end
        n_checks++;
        if (done_cnt != 0) begin n_fail++; $display("FAIL to_no_done: got %0d expected 0", done_cnt); end
        n_checks++;
        if (busy81 != 0) begin n_fail++; $display("FAIL to_busy: got %0d expected 0", busy81); end
        n_checks++;
        if (mc_max != 64) begin n_fail++; $display("FAIL to_mc_len: got %0d expected 64", mc_max); end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_sequence();
        test_stall();
        test_stale_start();
        test_reset_mid();
`ifdef AES_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
